insn_fetch_queue: RTL and testbench

- Fetch-side producer for the instruction converter.
- Issues sequential fetches to instruction memory and buffers the returned words in a DEPTH-entry in-order queue.
- Presents {PC, instruction} to the converter. Holds PC and instruction stable while the converter's ext_stall or the decode stall is high.
- On a branch redirect, flushes the queue and drops in-flight responses. Drives a sentinel PC during bubbles so the converter always recognises the next valid instruction as new.

---
 rtl/insn_fetch_queue_pkg.sv | 17 +
 rtl/insn_fetch_queue_fetch_fifo.sv | 52 +++++
 rtl/insn_fetch_queue.sv | 130 +++++++++++++
 tb/tb_insn_fetch_queue.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/insn_fetch_queue_pkg.sv
// Shared fetch-side definitions: datapath widths, the bubble sentinel PC and
// the queue entry layout used by insn_fetch_queue and its FIFO.
package insn_fetch_queue_pkg;

  localparam int unsigned PC_WIDTH    = 32;
  localparam int unsigned INSTR_WIDTH = 32;

  // Matches the converter's PC register reset value, so a bubble never aliases a real PC.
  localparam logic [PC_WIDTH-1:0] IFQ_INVALID_PC = 32'hFFFF_FFFF;
  localparam logic [PC_WIDTH-1:0] PC_INC         = 32'd4;

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/insn_fetch_queue_fetch_fifo.sv
// In-order synchronous FIFO for fetched {pc, instr} entries with single-cycle flush.
// Pointers carry one extra wrap bit so full/empty fall out of an MSB compare.
module insn_fetch_queue_fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = 1;

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count = wptr_q - rptr_q;
  assign head  = mem_q[rptr_q[AW-1:0]];

  assign do_pop  = pop && !empty;
  // At full occupancy the slot being written is the one popped this cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/insn_fetch_queue.sv
// Sequential instruction fetcher feeding the converter through an in-order queue.
// Define IFQ_BYPASS_EN to forward a response straight to out_* when the queue is empty.
module insn_fetch_queue
  import insn_fetch_queue_pkg::*;
#(
  parameter int unsigned          DEPTH     = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = 32'h0000_0000,
  parameter int unsigned          MAX_OUTST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    redirect_valid,
  input  logic [PC_WIDTH-1:0]     redirect_pc,
  output logic                    im_req_valid,
  output logic [PC_WIDTH-1:0]     im_req_addr,
  input  logic                    im_req_ready,
  input  logic                    im_rsp_valid,
  input  logic [INSTR_WIDTH-1:0]  im_rsp_data,
  input  logic                    id_stall,
  input  logic                    ext_stall,
  output logic                    out_valid,
  output logic [PC_WIDTH-1:0]     out_pc,
  output logic [INSTR_WIDTH-1:0]  out_instr
);

  localparam int unsigned CntW = $clog2(MAX_OUTST) + 1;
  localparam int unsigned OccW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] CntOne = 1;

  logic                rst_q;
  logic [PC_WIDTH-1:0] fpc_q, fpc_d, rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0]     outst_q, outst_d, drop_q, drop_d;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [OccW-1:0]     fifo_count;
  ifq_entry_t          fifo_head, rsp_entry;
  logic                req_fire, rsp_keep, pop, bypass;

  assign rsp_entry = '{pc: rsp_pc_q, instr: im_rsp_data};
  // Responses in the redirect cycle or owed to the drop count never reach the queue.
  assign rsp_keep  = im_rsp_valid && !redirect_valid && (drop_q == '0);

  // Queue slots are reserved at issue time, so a returning word always has room.
  assign im_req_valid = !rst_q && !redirect_valid &&
                        ((32'(fifo_count) + 32'(outst_q)) < DEPTH) &&
                        (32'(outst_q) < MAX_OUTST);
  assign im_req_addr  = fpc_q;
  assign req_fire     = im_req_valid && im_req_ready;

`ifdef IFQ_BYPASS_EN
  assign bypass = fifo_empty && rsp_keep;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    out_valid = 1'b0;
    out_pc    = IFQ_INVALID_PC;
    out_instr = '0;
    if (!fifo_empty) begin
      out_valid = 1'b1;
      out_pc    = fifo_head.pc;
      out_instr = fifo_head.instr;
    end else if (bypass) begin
      out_valid = 1'b1;
      out_pc    = rsp_pc_q;
      out_instr = im_rsp_data;
    end
  end

  assign pop       = out_valid && !ext_stall && !id_stall;
  assign fifo_pop  = pop && !redirect_valid && !fifo_empty;
  assign fifo_push = rsp_keep && !(bypass && pop);

  always_comb begin
    fpc_d    = fpc_q;
    rsp_pc_d = rsp_pc_q;
    outst_d  = outst_q;
    drop_d   = drop_q;
    if (req_fire) begin
      fpc_d   = fpc_q + PC_INC;
      outst_d = outst_d + CntOne;
    end
    if (im_rsp_valid) outst_d = outst_d - CntOne;
    if (redirect_valid) begin
      fpc_d    = redirect_pc;
      rsp_pc_d = redirect_pc;
      // Everything still in flight after this cycle belongs to the old stream.
      drop_d   = outst_d;
    end else if (im_rsp_valid) begin
      if (drop_q != '0) drop_d = drop_q - CntOne;
      else              rsp_pc_d = rsp_pc_q + PC_INC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_q    <= 1'b1;
      fpc_q    <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      outst_q  <= '0;
      drop_q   <= '0;
    end else begin
      rst_q    <= 1'b0;
      fpc_q    <= fpc_d;
      rsp_pc_q <= rsp_pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
    end
  end

  insn_fetch_queue_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(ifq_entry_t))
  ) u_fetch_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (rsp_entry),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head),
    .count (fifo_count)
  );

  overflow_a: assert property (@(posedge clk) disable iff (rst)
                               !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_insn_fetch_queue.sv
// Bench for insn_fetch_queue: directed scenarios then random traffic, all checked
// against a queue-level model of fetched, in-flight and presented instructions.
module tb_insn_fetch_queue;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MAX_OUTST = 4;
  localparam int          DEPTH_I   = 4;
  localparam int          OUTST_I   = 4;
  localparam logic [31:0] RESET_PC  = 32'h0000_0100;
  localparam logic [31:0] SENT      = 32'hFFFF_FFFF;
`ifdef IFQ_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        im_req_valid;
  logic [31:0] im_req_addr;
  logic        im_req_ready;
  logic        im_rsp_valid;
  logic [31:0] im_rsp_data;
  logic        id_stall;
  logic        ext_stall;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  insn_fetch_queue #(
    .DEPTH     (DEPTH),
    .RESET_PC  (RESET_PC),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im_req_valid   (im_req_valid),
    .im_req_addr    (im_req_addr),
    .im_req_ready   (im_req_ready),
    .im_rsp_valid   (im_rsp_valid),
    .im_rsp_data    (im_rsp_data),
    .id_stall       (id_stall),
    .ext_stall      (ext_stall),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          live;
  } req_t;

  req_t        pend[$];
  logic [31:0] mq[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] m_fpc;
  int          m_outst;
  bit          hold;
  bit          cur_live;
  logic [31:0] cur_addr;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          rnd_ready = 1'b0;
  bit          prev_held;
  logic [31:0] prev_pc, prev_instr;
  int          first_req_cyc, first_val_cyc;
  logic        s_valid, s_rv;
  bit          s_rsp_live;
  logic [31:0] s_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    logic        ev, erv;
    logic [31:0] ea;
    bit          popx;
    ev = (mq.size() > 0);
`ifdef IFQ_BYPASS_EN
    if (!ev && im_rsp_valid && cur_live && !redirect_valid) ev = 1'b1;
`endif
    ea  = (mq.size() > 0) ? mq[0] : cur_addr;
    erv = !hold && !redirect_valid && ((mq.size() + m_outst) < DEPTH_I) && (m_outst < OUTST_I);

    chk("out_valid", 32'(out_valid), 32'(ev));
    if (ev) begin
      chk("out_pc", out_pc, ea);
      chk("out_instr", out_instr, mem_word(ea));
    end else begin
      chk("sentinel_pc", out_pc, SENT);
      chk("bubble_instr", out_instr, 32'h0);
    end
    if (prev_held) begin
      chk("hold_pc", out_pc, prev_pc);
      chk("hold_instr", out_instr, prev_instr);
    end
    chk("im_req_valid", 32'(im_req_valid), 32'(erv));
    if (im_req_valid) chk("im_req_addr", im_req_addr, m_fpc);

    popx = ev && !ext_stall && !id_stall && !redirect_valid;
    if (ev && first_val_cyc < 0) first_val_cyc = cyc;
    if (popx) pop_log.push_back(ea);
    if (im_rsp_valid) begin
      m_outst--;
      if (cur_live && !redirect_valid) mq.push_back(cur_addr);
    end
    if (popx) void'(mq.pop_front());
    if (im_req_valid && im_req_ready) begin
      if (first_req_cyc < 0) first_req_cyc = cyc;
      pend.push_back('{addr: im_req_addr, due: cyc + int'($urandom_range(lat_max, lat_min)),
                       live: 1'b1});
      req_log.push_back(im_req_addr);
      m_outst++;
      m_fpc += 32'd4;
    end
    if (redirect_valid) begin
      foreach (pend[i]) pend[i].live = 1'b0;
      mq.delete();
      m_fpc = redirect_pc;
    end
    prev_held  = ev && (ext_stall || id_stall) && !redirect_valid;
    prev_pc    = out_pc;
    prev_instr = out_instr;
    hold       = 1'b0;
    s_valid    = out_valid;
    s_pc       = out_pc;
    s_rv       = im_req_valid;
    s_rsp_live = im_rsp_valid && cur_live && !redirect_valid;
  endtask

  task automatic drive_im();
    req_t r;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      r            = pend.pop_front();
      im_rsp_valid = 1'b1;
      im_rsp_data  = mem_word(r.addr);
      cur_live     = r.live;
      cur_addr     = r.addr;
    end else begin
      im_rsp_valid = 1'b0;
      im_rsp_data  = $urandom();
      cur_live     = 1'b0;
    end
    im_req_ready = rnd_ready ? ($urandom_range(3, 0) != 0) : 1'b1;
  endtask

  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
    drive_im();
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    ext_stall      = 1'b0;
    id_stall       = 1'b0;
    im_rsp_valid   = 1'b0;
    im_rsp_data    = '0;
    im_req_ready   = 1'b1;
    @(negedge clk);
    chk("rst_req_valid", 32'(im_req_valid), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_pc", out_pc, SENT);
    chk("rst_out_instr", out_instr, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
    pend.delete();
    mq.delete();
    req_log.delete();
    pop_log.delete();
    m_fpc         = RESET_PC;
    m_outst       = 0;
    hold          = 1'b1;
    prev_held     = 1'b0;
    cur_live      = 1'b0;
    cur_addr      = '0;
    first_req_cyc = -1;
    first_val_cyc = -1;
    drive_im();
  endtask

  task automatic redirect(input logic [31:0] pc);
    req_log.delete();
    pop_log.delete();
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cycle();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_pop(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      if (pop_log.size() > 0) found = 1'b1;
    end
    chk(tag, 32'(found), 32'h1);
  endtask

  task automatic wait_valid(input string tag, output int bubbles);
    bit found;
    found   = 1'b0;
    bubbles = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      if (s_valid) found = 1'b1;
      else bubbles++;
    end
    chk(tag, 32'(found), 32'h1);
  endtask

  initial begin
    int          bub;
    bit          found;
    logic [31:0] tmp;

    // Reset, steady fetch with 1-cycle memory
    do_reset();
    repeat (10) cycle();
    chk("first_latency", 32'(first_val_cyc - first_req_cyc), 32'(EXP_LAT));
    chk("req_log_n", 32'(req_log.size() >= 4), 32'h1);
    chk("req0", req_log[0], 32'h100);
    chk("req1", req_log[1], 32'h104);
    chk("req2", req_log[2], 32'h108);
    chk("req3", req_log[3], 32'h10C);
    chk("pop0", pop_log[0], 32'h100);

    // ext_stall held on head 0x104
    redirect(32'h100);
    wait_pop("tmo_pop_100");
    ext_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("stall_valid", 32'(s_valid), 32'h1);
      chk("stall_pc", s_pc, 32'h104);
    end
    chk("stall_backpressure", 32'(s_rv), 32'h0);
    ext_stall = 1'b0;

    // Redirect with two requests in flight
    lat_min = 3;
    lat_max = 3;
    found   = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (m_outst == 2) found = 1'b1;
    end
    chk("tmo_outst2", 32'(found), 32'h1);
    redirect(32'h200);
    lat_min = 1;
    lat_max = 1;
    wait_valid("tmo_valid_200", bub);
    chk("redir_bubble", 32'(bub > 0), 32'h1);
    chk("redir_pc", s_pc, 32'h200);

    // Redirect to the held head PC
    redirect(32'h100);
    wait_pop("tmo_pop_100b");
    ext_stall = 1'b1;
    cycle();
    chk("same_head_pc", s_pc, 32'h104);
    redirect(32'h104);
    cycle();
    chk("same_redir_bubble", 32'(s_valid), 32'h0);
    ext_stall = 1'b0;
    wait_valid("tmo_valid_104", bub);
    chk("same_redir_pc", s_pc, 32'h104);

    // Fetch address wrap
    redirect(32'hFFFF_FFF8);
    repeat (12) cycle();
    chk("wrap_req_n", 32'(req_log.size() >= 3), 32'h1);
    chk("wrap_req0", req_log[0], 32'hFFFF_FFF8);
    chk("wrap_req1", req_log[1], 32'hFFFF_FFFC);
    chk("wrap_req2", req_log[2], 32'h0000_0000);
    chk("wrap_pop_n", 32'(pop_log.size() >= 3), 32'h1);
    chk("wrap_pop0", pop_log[0], 32'hFFFF_FFF8);
    chk("wrap_pop1", pop_log[1], 32'hFFFF_FFFC);
    chk("wrap_pop2", pop_log[2], 32'h0000_0000);

`ifdef IFQ_BYPASS_EN
    // Same-cycle forwarding into an empty queue
    redirect(32'h300);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      if (s_rsp_live) found = 1'b1;
    end
    chk("tmo_rsp_300", 32'(found), 32'h1);
    chk("bypass_valid", 32'(s_valid), 32'h1);
    chk("bypass_pc", s_pc, 32'h300);
    cycle();
    chk("bypass_next_pc", s_pc, 32'h304);
`endif

    // Random traffic
    rnd_ready = 1'b1;
    lat_min   = 1;
    lat_max   = 4;
    for (int i = 0; i < 1500; i++) begin
      ext_stall      = ($urandom_range(4, 0) == 0);
      id_stall       = ($urandom_range(9, 0) == 0);
      redirect_valid = ($urandom_range(29, 0) == 0);
      tmp            = $urandom();
      redirect_pc    = {tmp[31:2], 2'b00};
      cycle();
    end
    redirect_valid = 1'b0;
    ext_stall      = 1'b0;
    id_stall       = 1'b0;
    repeat (5) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
